serial_adder: RTL and testbench

Bit-serial unsigned adder. It is the responder side of the load/start/done operand handshake that the block-level bench drives. Operands are captured on `load` and added LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop once `start` is seen. `sum`/`cout` are presented with a level `done` that stays high until the initiator releases `start`.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_full_adder_bit.sv | 18 +
 rtl/serial_adder.sv | 154 +++++++++++++++
 tb/tb_serial_adder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   sa_state_t       : control FSM state encoding
//   SA_DEFAULT_WIDTH : default operand/sum width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOADED,
    RUN,
    DONE
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 4;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_bit.sv
// full_adder_bit
//   Single combinational full-adder cell used by the serial datapath.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of a, b, cin)
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_bit

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial unsigned adder. Operands are captured on load and added
//   LSB-first, one bit per clock, once start is seen. The result is held
//   with a level done until start is released.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   load  : capture A/B
//   start : begin / hold the operation
//   A, B  : operands (WIDTH bits)
//   sum   : (A+B) mod 2^WIDTH, valid while done
//   cout  : carry out of the MSB, valid while done
//   done  : result valid
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  // Counter value seen on the final (WIDTH-th) RUN edge.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t        state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] s_sh_reg, s_sh_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             done_reg, done_next;

  logic fa_s;
  logic fa_cout;

  full_adder_bit u_fa (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      s_sh_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      s_sh_reg  <= s_sh_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    s_sh_next  = s_sh_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    done_next  = done_reg;

    case (state_reg)
      IDLE: begin
        if (load) begin
          a_sh_next  = A;
          b_sh_next  = B;
          s_sh_next  = '0;
          carry_next = 1'b0;
          state_next = LOADED;
        end
      end

      LOADED: begin
        // A fresh load wins over start so the latest operands are used.
        if (load) begin
          a_sh_next  = A;
          b_sh_next  = B;
          s_sh_next  = '0;
          carry_next = 1'b0;
        end else if (start) begin
          cnt_next   = '0;
          state_next = RUN;
        end
      end

      RUN: begin
        carry_next = fa_cout;
        a_sh_next  = a_sh_reg >> 1;
        b_sh_next  = b_sh_reg >> 1;
        s_sh_next  = {fa_s, s_sh_reg[WIDTH-1:1]};
        cnt_next   = cnt_reg + CW'(1);
        // The last sum bit is still in flight, so publish the shifted
        // value directly rather than waiting a cycle for s_sh.
        if (cnt_reg == LAST) begin
          sum_next   = {fa_s, s_sh_reg[WIDTH-1:1]};
          cout_next  = fa_cout;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end

      DONE: begin
        if (load) begin
          a_sh_next  = A;
          b_sh_next  = B;
          s_sh_next  = '0;
          carry_next = 1'b0;
          sum_next   = '0;
          cout_next  = 1'b0;
          done_next  = 1'b0;
          state_next = LOADED;
        end else if (!start) begin
          // Result stays on sum/cout for inspection after done falls.
          done_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign done = done_reg;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed-vector bench for serial_adder (WIDTH=4 and WIDTH=8 instances).
//   Stimulus pushes expected results into per-instance queues; monitors pop
//   and compare on each rising edge of done, including completion time.
module tb_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    int          due;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       load4, start4;
  logic [3:0] a4, b4, sum4;
  logic       cout4, done4;
  logic       load8, start8;
  logic [7:0] a8, b8, sum8;
  logic       cout8, done8;

  int   cyc        = 0;
  int   pass_cnt   = 0;
  int   total_cnt  = 0;
  logic done4_prev = 1'b0;
  logic done8_prev = 1'b0;
  exp_t q4[$];
  exp_t q8[$];

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .load  (load4),
    .start (start4),
    .A     (a4),
    .B     (b4),
    .sum   (sum4),
    .cout  (cout4),
    .done  (done4)
  );

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .load  (load8),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .sum   (sum8),
    .cout  (cout8),
    .done  (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitors: one comparison set per rising edge of done.
  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1 && done4_prev === 1'b0) begin
      if (q4.size() == 0) begin
        total_cnt++;
        $display("FAIL w4_unexpected_done: got sum %0d with nothing expected", sum4);
      end else begin
        e = q4.pop_front();
        chk("w4_sum", 32'(sum4), e.sum);
        chk("w4_cout", 32'(cout4), 32'(e.cout));
        chk("w4_latency", cyc, e.due);
      end
    end
    done4_prev = done4;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1 && done8_prev === 1'b0) begin
      if (q8.size() == 0) begin
        total_cnt++;
        $display("FAIL w8_unexpected_done: got sum %0d with nothing expected", sum8);
      end else begin
        e = q8.pop_front();
        chk("w8_sum", 32'(sum8), e.sum);
        chk("w8_cout", 32'(cout8), 32'(e.cout));
        chk("w8_latency", cyc, e.due);
      end
    end
    done8_prev = done8;
  end

  // Load, then start on the next edge; sum must hold prev until completion.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] es, input logic ec,
                        input logic [3:0] prev, input bit release_start);
    a4 = a; b4 = b; load4 = 1'b1;
    tick(1);
    load4 = 1'b0; start4 = 1'b1;
    a4 = ~a; b4 = ~b;  // must not affect the captured operands
    q4.push_back('{sum: 32'(es), cout: ec, due: cyc + 1 + 4});
    for (int i = 0; i < 5; i++) begin
      chk("w4_sum_hidden", 32'(sum4), 32'(prev));
      chk("w4_done_early", 32'(done4), 0);
      tick(1);
    end
    chk("w4_done_high", 32'(done4), 1);
    $display("op %0d+%0d -> sum %0d cout %0d done %0d", a, b, sum4, cout4, done4);
    if (release_start) begin
      start4 = 1'b0;
      tick(1);
      chk("w4_done_fall", 32'(done4), 0);
      chk("w4_sum_retained", 32'(sum4), 32'(es));
    end
  endtask

  initial begin
    rst = 1'b1; load4 = 1'b0; start4 = 1'b0; a4 = '0; b4 = '0;
    load8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
    tick(2);
    rst = 1'b0;
    chk("reset_done", 32'(done4), 0);
    chk("reset_sum", 32'(sum4), 0);
    chk("reset_cout", 32'(cout4), 0);
    chk("reset_done8", 32'(done8), 0);

    run_op(4'd4, 4'd5, 4'd9, 1'b0, 4'd0, 1'b1);
    run_op(4'd0, 4'd0, 4'd0, 1'b0, 4'd9, 1'b1);

    // Load without start: nothing must complete.
    a4 = 4'd6; b4 = 4'd2; load4 = 1'b1;
    tick(1);
    load4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("noload_done", 32'(done4), 0);
      chk("noload_sum", 32'(sum4), 0);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst2_done", 32'(done4), 0);
    chk("rst2_sum", 32'(sum4), 0);
    chk("rst2_cout", 32'(cout4), 0);
    $display("load-only then reset: done %0d sum %0d", done4, sum4);

    run_op(4'b1100, 4'b1011, 4'b0111, 1'b1, 4'd0, 1'b1);

    // Reset two edges into RUN.
    a4 = 4'd12; b4 = 4'd11; load4 = 1'b1;
    tick(1);
    load4 = 1'b0; start4 = 1'b1;
    tick(3);  // start sampled, then two RUN edges
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrun_done", 32'(done4), 0);
    chk("midrun_sum", 32'(sum4), 0);
    chk("midrun_cout", 32'(cout4), 0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("start_no_load", 32'(done4), 0);
    end
    $display("mid-run reset: done %0d sum %0d cout %0d", done4, sum4, cout4);
    start4 = 1'b0;
    tick(1);

    // Reach DONE with start held, then reload from DONE.
    run_op(4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 1'b0);
    a4 = 4'd3; b4 = 4'd3; load4 = 1'b1;
    tick(1);
    load4 = 1'b0;
    chk("reload_done", 32'(done4), 0);
    chk("reload_sum", 32'(sum4), 0);
    q4.push_back('{sum: 32'd6, cout: 1'b0, due: cyc + 1 + 4});
    tick(5);
    chk("reload_done_high", 32'(done4), 1);
    $display("reload 3+3 -> sum %0d done %0d", sum4, done4);
    start4 = 1'b0;
    tick(1);

    // load and start together in IDLE: start takes effect one edge later.
    a4 = 4'd7; b4 = 4'd8; load4 = 1'b1; start4 = 1'b1;
    q4.push_back('{sum: 32'd15, cout: 1'b0, due: cyc + 2 + 4});
    tick(1);
    load4 = 1'b0;
    tick(4);
    chk("both_not_yet", 32'(done4), 0);
    tick(1);
    chk("both_done", 32'(done4), 1);
    $display("load+start 7+8 -> sum %0d done %0d", sum4, done4);
    start4 = 1'b0;
    tick(1);

    // WIDTH=8 overflow.
    a8 = 8'd255; b8 = 8'd1; load8 = 1'b1;
    tick(1);
    load8 = 1'b0; start8 = 1'b1;
    q8.push_back('{sum: 32'd0, cout: 1'b1, due: cyc + 1 + 8});
    tick(9);
    chk("w8_done_high", 32'(done8), 1);
    $display("w8 255+1 -> sum %0d cout %0d done %0d", sum8, cout8, done8);
    start8 = 1'b0;
    tick(1);
    chk("w8_done_fall", 32'(done8), 0);

    tick(3);
    chk("q4_drained", q4.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_serial_adder
